// File: rtl/regfile_rand_driver_if.sv
// Register-file port bundle between the random driver (master) and the dual-read file (slave).
// Write port: we/addr_rd/data_in. Read ports: addr_rs1/addr_rs2 with combinational rs1/rs2.
interface regfile_rand_driver_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic         we;
    logic [N-1:0] addr_rd;
    logic [W-1:0] data_in;
    logic [N-1:0] addr_rs1;
    logic [N-1:0] addr_rs2;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;

    modport master (output we, addr_rd, data_in, addr_rs1, addr_rs2, input rs1, rs2);
    modport slave  (input we, addr_rd, data_in, addr_rs1, addr_rs2, output rs1, rs2);
endinterface

// File: rtl/regfile_rand_driver.sv
// LFSR-driven fill/read exerciser for a dual-read register file; returns rs1+rs2 per read.
// Optional REGFILE_DRV_SHADOW_EN keeps a shadow copy and flags readback errors on mismatch.
module regfile_rand_driver #(
    parameter int          N           = 4,
    parameter int          W           = 8,
    parameter int          TICK_CYCLES = 4,
    parameter int          READS       = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [W:0]            result,
    output logic                  result_valid,
    output logic                  mismatch,
    regfile_rand_driver_if.master rf
);
    localparam logic [15:0]  SEED_EFF  = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam int           TW        = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int           CW        = $clog2(READS + 1);
    localparam logic [N-1:0] LAST_ADDR = {N{1'b1}};

    typedef enum logic [1:0] {IDLE, FILL, READ, DONE} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick;
    logic [15:0]   lfsr, lfsr_nxt;
    logic [CW-1:0] op_cnt;
    logic [N-1:0]  wr_ptr, rs2_addr;
    logic          tick_hit, wr_issue, rd_issue;
    logic [1:0]    vld_pipe;
    logic          we_q;
    logic [N-1:0]  addr_rd_q, addr_rs1_q, addr_rs2_q;
    logic [W-1:0]  data_q;

    assign tick_hit    = (tick == TW'(TICK_CYCLES - 1));
    assign wr_issue    = (state == FILL) && tick_hit;
    assign rd_issue    = (state == READ) && tick_hit && (op_cnt < CW'(READS));
    assign vld_pipe[0] = rd_issue;
    assign lfsr_nxt    = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Upper read address takes bits N..2N-1, wrapping back into the 16-bit LFSR
    always_comb begin
        rs2_addr = '0;
        for (int i = 0; i < N; i++) rs2_addr[i] = lfsr[(N + i) % 16];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (wr_issue && wr_ptr == LAST_ADDR) state_nxt = READ;
            READ:    if (result_valid && op_cnt == CW'(READS)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            tick   <= '0;
            op_cnt <= '0;
            wr_ptr <= N'(1);
            lfsr   <= SEED_EFF;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                tick   <= '0;
                op_cnt <= '0;
                wr_ptr <= N'(1);
            end else begin
                tick <= tick_hit ? '0 : tick + 1'b1;
                if (rd_issue) op_cnt <= op_cnt + 1'b1;
                if (wr_issue) wr_ptr <= wr_ptr + 1'b1;
            end
            if (wr_issue || rd_issue) lfsr <= lfsr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q         <= 1'b0;
            addr_rd_q    <= '0;
            data_q       <= '0;
            addr_rs1_q   <= '0;
            addr_rs2_q   <= '0;
            vld_pipe[1]  <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            we_q <= wr_issue;
            if (wr_issue) begin
                addr_rd_q <= wr_ptr;
                data_q    <= lfsr[W-1:0];
            end
            if (rd_issue) begin
                addr_rs1_q <= lfsr[N-1:0];
                addr_rs2_q <= rs2_addr;
            end
            vld_pipe[1]  <= vld_pipe[0];
            result_valid <= vld_pipe[1];
            if (vld_pipe[1]) result <= {1'b0, rf.rs1} + {1'b0, rf.rs2};
        end
    end

    assign rf.we       = we_q;
    assign rf.addr_rd  = addr_rd_q;
    assign rf.data_in  = data_q;
    assign rf.addr_rs1 = addr_rs1_q;
    assign rf.addr_rs2 = addr_rs2_q;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

`ifdef REGFILE_DRV_SHADOW_EN
    logic [W-1:0] shadow [2**N];

    // Entry 0 is never written, so it stays at its reset value of 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**N; i++) shadow[i] <= '0;
            mismatch <= 1'b0;
        end else begin
            if (wr_issue) shadow[wr_ptr] <= lfsr[W-1:0];
            if (vld_pipe[1] && (rf.rs1 != shadow[addr_rs1_q] || rf.rs2 != shadow[addr_rs2_q]))
                mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif
endmodule
